// File: rtl/mxint8_alu_scheduler.sv
// Round-robin scheduler sharing one fixed-latency MXINT8 block ALU among NUM_REQ requesters.
// Payloads pass through bit-exact; a tag pipeline routes each result back to its requester.
module mxint8_alu_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int ALU_LAT    = 3,
   parameter int BLOCK_SIZE = 32,
   parameter int ELEM_W     = 8,
   parameter int SCALE_W    = 8,
   parameter int PW         = SCALE_W + BLOCK_SIZE*ELEM_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [2*NUM_REQ-1:0]  req_op,
   input  logic [PW*NUM_REQ-1:0] req_a,
   input  logic [PW*NUM_REQ-1:0] req_b,
   output logic                  alu_in_valid,
   output logic [1:0]            alu_op,
   output logic [PW-1:0]         alu_a,
   output logic [PW-1:0]         alu_b,
   input  logic                  alu_out_valid,
   input  logic [PW-1:0]         alu_out,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [PW*NUM_REQ-1:0] rsp_data,
   output logic [NUM_REQ-1:0]    rsp_err,
   output logic                  busy,
   output logic                  protocol_err
);

   localparam int         IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [1:0] OP_RSV = 2'b11;

   logic [NUM_REQ-1:0] outstanding;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] rsp_hs;
   logic [NUM_REQ-1:0] alu_ld;
   logic [NUM_REQ-1:0] rsv_ld;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      grant_idx;
   logic [IW-1:0]      cand_idx;
   logic               grant_any;
   logic               issue;
   int                 cand;
   logic [1:0]         sel_op;
   logic [PW-1:0]      sel_a;
   logic [PW-1:0]      sel_b;
   logic [ALU_LAT:0]   tag_valid;
   logic [IW-1:0]      tag_idx [ALU_LAT+1];
   logic [PW-1:0]      rsp_buf [NUM_REQ];

   assign eligible  = req_valid & ~outstanding;
   assign req_ready = grant;
   assign rsp_hs    = rsp_valid & rsp_ready;
   assign busy      = |outstanding;

   // First eligible index at or after ptr, wrapping around.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IW'(cand);
         if (!grant_any && eligible[cand_idx]) begin
            grant_any       = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_op = req_op[2*i +: 2];
            sel_a  = req_a[PW*i +: PW];
            sel_b  = req_b[PW*i +: PW];
         end
      end
   end

   assign issue  = grant_any && (sel_op != OP_RSV);
   assign rsv_ld = grant & {NUM_REQ{grant_any && (sel_op == OP_RSV)}};

   always_comb begin
      alu_ld = '0;
      for (int i = 0; i < NUM_REQ; i++)
         alu_ld[i] = tag_valid[ALU_LAT] && (tag_idx[ALU_LAT] == IW'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         outstanding <= '0;
      end else begin
         outstanding <= (outstanding & ~rsp_hs) | grant;
         if (grant_any)
            ptr <= (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Operand registers hold their last value when nothing is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_in_valid <= 1'b0;
         alu_op       <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
      end else begin
         alu_in_valid <= issue;
         if (issue) begin
            alu_op <= sel_op;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
         end
      end
   end

   // Stage 0 lines up with alu_in_valid, stage ALU_LAT with the expected alu_out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
         for (int k = 0; k <= ALU_LAT; k++) tag_idx[k] <= '0;
      end else begin
         tag_valid  <= {tag_valid[ALU_LAT-1:0], issue};
         tag_idx[0] <= grant_idx;
         for (int k = 1; k <= ALU_LAT; k++) tag_idx[k] <= tag_idx[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         protocol_err <= 1'b0;
      else if (alu_out_valid != tag_valid[ALU_LAT])
         protocol_err <= 1'b1;
   end

   // The tag alone decides the load, so a missing alu_out_valid still fills the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_err   <= '0;
         for (int i = 0; i < NUM_REQ; i++) rsp_buf[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (alu_ld[i]) begin
               rsp_valid[i] <= 1'b1;
               rsp_err[i]   <= 1'b0;
               rsp_buf[i]   <= alu_out;
            end else if (rsv_ld[i]) begin
               rsp_valid[i] <= 1'b1;
               rsp_err[i]   <= 1'b1;
               rsp_buf[i]   <= '0;
            end else if (rsp_hs[i]) begin
               rsp_valid[i] <= 1'b0;
               rsp_err[i]   <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
      assign rsp_data[PW*g +: PW] = rsp_buf[g];
   end

endmodule

// File: tb/tb_mxint8_alu_scheduler.sv
// Bench for mxint8_alu_scheduler: behavioural ALU stand-in, per-requester scoreboard,
// a vector table of single operations and hand-written arbitration/stall/reset sequences.
module tb_mxint8_alu_scheduler;

   localparam int NUM_REQ    = 4;
   localparam int ALU_LAT    = 3;
   localparam int BLOCK_SIZE = 32;
   localparam int ELEM_W     = 8;
   localparam int SCALE_W    = 8;
   localparam int PW         = SCALE_W + BLOCK_SIZE*ELEM_W;

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [2*NUM_REQ-1:0]  req_op;
   logic [PW*NUM_REQ-1:0] req_a;
   logic [PW*NUM_REQ-1:0] req_b;
   logic                  alu_in_valid;
   logic [1:0]            alu_op;
   logic [PW-1:0]         alu_a;
   logic [PW-1:0]         alu_b;
   logic                  alu_out_valid;
   logic [PW-1:0]         alu_out;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [PW*NUM_REQ-1:0] rsp_data;
   logic [NUM_REQ-1:0]    rsp_err;
   logic                  busy;
   logic                  protocol_err;

   mxint8_alu_scheduler #(
      .NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT), .BLOCK_SIZE(BLOCK_SIZE),
      .ELEM_W(ELEM_W), .SCALE_W(SCALE_W), .PW(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .alu_in_valid(alu_in_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out_valid(alu_out_valid), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .protocol_err(protocol_err)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   // Reference MXINT8 ALU: NEG/ADD keep a's scale, MUL sums scales; elements wrap.
   function automatic logic [PW-1:0] alu_fn(input logic [1:0] op, input logic [PW-1:0] a,
                                            input logic [PW-1:0] b);
      logic [PW-1:0]      r;
      logic [ELEM_W-1:0]  ea, eb;
      r = '0;
      case (op)
         2'b10:   r[PW-1 -: SCALE_W] = SCALE_W'(a[PW-1 -: SCALE_W] + b[PW-1 -: SCALE_W]);
         default: r[PW-1 -: SCALE_W] = a[PW-1 -: SCALE_W];
      endcase
      for (int k = 0; k < BLOCK_SIZE; k++) begin
         ea = a[PW-SCALE_W-1-k*ELEM_W -: ELEM_W];
         eb = b[PW-SCALE_W-1-k*ELEM_W -: ELEM_W];
         case (op)
            2'b00:   r[PW-SCALE_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(0 - ea);
            2'b01:   r[PW-SCALE_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(ea + eb);
            default: r[PW-SCALE_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(ea * eb);
         endcase
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] rand_block();
      logic [PW-1:0] r;
      r = '0;
      for (int k = 0; k < PW/8; k++) r[8*k +: 8] = 8'($urandom);
      return r;
   endfunction

   // ALU stand-in: fixed ALU_LAT pipeline, flushed by reset, plus a stray-strobe injector.
   logic [ALU_LAT-1:0] am_v;
   logic [1:0]         am_op [ALU_LAT];
   logic [PW-1:0]      am_a  [ALU_LAT];
   logic [PW-1:0]      am_b  [ALU_LAT];
   logic               stray;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         am_v <= '0;
         for (int k = 0; k < ALU_LAT; k++) begin
            am_op[k] <= '0; am_a[k] <= '0; am_b[k] <= '0;
         end
      end else begin
         am_v     <= {am_v[ALU_LAT-2:0], alu_in_valid};
         am_op[0] <= alu_op; am_a[0] <= alu_a; am_b[0] <= alu_b;
         for (int k = 1; k < ALU_LAT; k++) begin
            am_op[k] <= am_op[k-1]; am_a[k] <= am_a[k-1]; am_b[k] <= am_b[k-1];
         end
      end
   end

   assign alu_out_valid = am_v[ALU_LAT-1] | stray;
   assign alu_out       = alu_fn(am_op[ALU_LAT-1], am_a[ALU_LAT-1], am_b[ALU_LAT-1]);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_pl(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // Scoreboard: expectation pushed on request handshake, popped on response handshake.
   typedef struct {
      int            idx;
      logic [PW-1:0] data;
      logic          err;
   } sb_t;
   sb_t        sb[$];
   sb_t        sb_e;
   int         sb_found;
   logic [1:0] sb_op;

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb_op  = req_op[2*i +: 2];
               sb_e.idx = i;
               if (sb_op == 2'b11) begin
                  sb_e.data = '0; sb_e.err = 1'b1;
               end else begin
                  sb_e.data = alu_fn(sb_op, req_a[PW*i +: PW], req_b[PW*i +: PW]);
                  sb_e.err  = 1'b0;
               end
               sb.push_back(sb_e);
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
               sb_found = -1;
               for (int j = 0; j < sb.size(); j++)
                  if (sb_found < 0 && sb[j].idx == i) sb_found = j;
               if (sb_found < 0) begin
                  n_vec++; n_err++;
                  $display("FAIL sb_unexpected @cyc %0d: response on requester %0d, none expected", cyc, i);
               end else begin
                  chk_pl("sb_data", rsp_data[PW*i +: PW], sb[sb_found].data);
                  chk("sb_err", 64'(rsp_err[i]), 64'(sb[sb_found].err));
                  sb.delete(sb_found);
               end
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_alu_in_valid"}, 64'(alu_in_valid), 0);
      chk({tag, "_alu_op"},       64'(alu_op), 0);
      chk({tag, "_alu_ab_nz"},    64'((alu_a != '0) || (alu_b != '0)), 0);
      chk({tag, "_rsp_valid"},    64'(rsp_valid), 0);
      chk({tag, "_rsp_err"},      64'(rsp_err), 0);
      chk({tag, "_rsp_data_nz"},  64'(rsp_data != '0), 0);
      chk({tag, "_busy"},         64'(busy), 0);
      chk({tag, "_protocol_err"}, 64'(protocol_err), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; req_valid = '0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic set_req(input int idx, input logic [1:0] op, input logic [PW-1:0] a,
                          input logic [PW-1:0] b);
      req_op[2*idx +: 2]  = op;
      req_a[PW*idx +: PW] = a;
      req_b[PW*idx +: PW] = b;
   endtask

   // One isolated operation: grant, issue offset, response latency and error flag.
   task automatic run_one(input int idx, input logic [1:0] op, input logic exp_err,
                          input int exp_lat, input int exp_issues);
      int t_hs, first_issue, issues, rc;
      logic err_seen;
      set_req(idx, op, rand_block(), rand_block());
      req_valid[idx] = 1'b1;
      t_hs = -1;
      for (int w = 0; w < 20 && t_hs < 0; w++) begin
         @(negedge clk);
         if (req_ready[idx]) t_hs = cyc;
         @(posedge clk); #1;
      end
      req_valid[idx] = 1'b0;
      chk("run_granted", 64'(t_hs >= 0), 1);
      issues = 0; first_issue = -1; rc = -1; err_seen = 1'b0;
      for (int w = 0; w < 20 && rc < 0; w++) begin
         @(negedge clk);
         if (alu_in_valid) begin
            issues++;
            if (first_issue < 0) first_issue = cyc;
         end
         if (rsp_valid[idx]) begin
            rc = cyc; err_seen = rsp_err[idx];
         end
         @(posedge clk); #1;
      end
      chk("run_latency", 64'((rc < 0) ? -1 : rc - t_hs), 64'(exp_lat));
      chk("run_issues", 64'(issues), 64'(exp_issues));
      chk("run_issue_offset", 64'((first_issue < 0) ? -1 : first_issue - t_hs),
          64'((exp_issues > 0) ? 1 : -1));
      chk("run_rsp_err", 64'(err_seen), 64'(exp_err));
   endtask

   typedef struct {
      int         idx;
      logic [1:0] op;
      logic       err;
      int         lat;
      int         issues;
   } vec_t;
   vec_t vt[8];

   logic [PW-1:0]      pa, pb, exp1;
   logic [NUM_REQ-1:0] rr_exp[7];
   int                 g0, t_wait;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1, 2'b01, 1'b0, 5, 1};
      vt[1] = '{2, 2'b10, 1'b0, 5, 1};
      vt[2] = '{3, 2'b00, 1'b0, 5, 1};
      vt[3] = '{2, 2'b11, 1'b1, 1, 0};
      vt[4] = '{0, 2'b10, 1'b0, 5, 1};
      vt[5] = '{3, 2'b01, 1'b0, 5, 1};
      vt[6] = '{1, 2'b11, 1'b1, 1, 0};
      vt[7] = '{0, 2'b01, 1'b0, 5, 1};
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

      rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      rsp_ready = '1; stray = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // NEG on requester 0 with handshake at cycle 5
      pa = '0;
      pa[PW-1 -: SCALE_W] = 8'h7F;
      for (int k = 0; k < BLOCK_SIZE; k++) pa[PW-SCALE_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(k);
      pb = rand_block();
      while (cyc < 5) begin @(posedge clk); #1; end
      set_req(0, 2'b00, pa, pb);
      req_valid[0] = 1'b1;
      for (int c = 5; c <= 12; c++) begin
         @(negedge clk);
         chk("neg_req_ready", 64'(req_ready[0]), 64'(c == 5));
         chk("neg_alu_in_valid", 64'(alu_in_valid), 64'(c == 6));
         chk("neg_rsp_valid", 64'(rsp_valid[0]), 64'(c == 10));
         chk("neg_busy", 64'(busy), 64'(c >= 6 && c <= 10));
         if (c == 6) chk("neg_alu_op", 64'(alu_op), 0);
         if (c == 10) chk_pl("neg_data", rsp_data[PW-1:0], alu_fn(2'b00, pa, pb));
         @(posedge clk); #1;
         if (c == 5) req_valid[0] = 1'b0;
      end

      for (int v = 0; v < 8; v++)
         run_one(vt[v].idx, vt[v].op, vt[v].err, vt[v].lat, vt[v].issues);

      // All requesters contend from cycle 0 after reset
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'(1 + (i % 2)), rand_block(), rand_block());
      req_valid = '1;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         chk("rr_grant", 64'(req_ready), 64'(rr_exp[c]));
         @(posedge clk); #1;
      end
      req_valid = '0;
      t_wait = 0;
      while (busy && t_wait < 40) begin @(posedge clk); #1; t_wait++; end
      chk("rr_drain", 64'(busy), 0);

      // Requester 1 stalled on its response while requester 0 keeps streaming
      pa = rand_block(); pb = rand_block();
      exp1 = alu_fn(2'b01, pa, pb);
      rsp_ready[1] = 1'b0;
      set_req(1, 2'b01, pa, pb);
      set_req(0, 2'b10, rand_block(), rand_block());
      req_valid[1] = 1'b1; req_valid[0] = 1'b1;
      t_wait = 0;
      while (!rsp_valid[1] && t_wait < 30) begin @(posedge clk); #1; t_wait++; end
      chk("stall_rsp_arrived", 64'(rsp_valid[1]), 1);
      g0 = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("stall_rsp_valid", 64'(rsp_valid[1]), 1);
         chk("stall_req_ready", 64'(req_ready[1]), 0);
         chk_pl("stall_rsp_data", rsp_data[PW +: PW], exp1);
         if (req_ready[0]) g0++;
         @(posedge clk); #1;
      end
      chk("stall_others_granted", 64'(g0 >= 2), 1);
      req_valid = '0; rsp_ready = '1;
      t_wait = 0;
      while (busy && t_wait < 40) begin @(posedge clk); #1; t_wait++; end
      chk("stall_drain", 64'(busy), 0);

      // Reset two cycles after an issue drops the operation
      do_reset();
      set_req(3, 2'b00, rand_block(), rand_block());
      req_valid[3] = 1'b1;
      @(negedge clk);
      chk("rst_mid_grant", 64'(req_ready), 64'(4'b1000));
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      @(negedge clk);
      chk("rst_mid_issue", 64'(alu_in_valid), 1);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk_zero("rst_mid");
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", 64'(rsp_valid), 0);
         chk("rst_mid_no_perr", 64'(protocol_err), 0);
         @(posedge clk); #1;
      end
      run_one(3, 2'b01, 1'b0, 5, 1);

      // Stray ALU strobe with nothing in flight
      stray = 1'b1;
      @(negedge clk);
      chk("stray_perr_before", 64'(protocol_err), 0);
      @(posedge clk); #1 stray = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stray_perr_sticky", 64'(protocol_err), 1);
         chk("stray_no_rsp", 64'(rsp_valid), 0);
         @(posedge clk); #1;
      end

      chk("sb_empty", 64'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mxint8_alu_scheduler.md
# mxint8_alu_scheduler

Round-robin scheduler that shares one fixed-latency MXINT8 block ALU (negate/add/multiply on a scale plus BLOCK_SIZE elements) among NUM_REQ requesters. It accepts operand blocks over per-requester valid/ready, issues at most one operation per cycle to the ALU, tracks in-flight operations with a tag pipeline, and returns each result to its originating requester through a one-entry response buffer. It sits between the vector-unit front ends and the MX ALU datapath.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ALU_LAT, 3: ALU cycles from alu_in_valid to alu_out_valid, at least 1
- BLOCK_SIZE, 32: elements per MX block
- ELEM_W, 8: MXINT8 element width
- SCALE_W, 8: shared scale width
- PW, SCALE_W+BLOCK_SIZE*ELEM_W: block payload width, {scale, elem[0], ..., elem[BLOCK_SIZE-1]}
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  one-hot grant (0 or 1 bit set)
- req_op  in  2*NUM_REQ  opcode per requester: 00 NEG, 01 ADD, 10 MUL, 11 reserved
- req_a, req_b  in  PW*NUM_REQ  operand blocks per requester; req_b ignored for NEG
- alu_in_valid  out  1  issue strobe to ALU
- alu_op  out  2  opcode to ALU
- alu_a, alu_b  out  PW  operands to ALU
- alu_out_valid  in  1  ALU result strobe
- alu_out  in  PW  ALU result block
- rsp_valid  out  NUM_REQ  response buffer full
- rsp_ready  in  NUM_REQ  response accepted
- rsp_data  out  PW*NUM_REQ  result block per requester
- rsp_err  out  NUM_REQ  response carries a reserved-opcode error
- busy  out  1  any requester outstanding
- protocol_err  out  1  sticky ALU protocol violation

## Operation
- outstanding[i] is set on the req handshake of requester i. It is cleared on the cycle after the rsp_valid[i] & rsp_ready[i] handshake. Each requester has at most one operation in flight, so response buffers never overflow.
- Requester i is eligible when req_valid[i] & ~outstanding[i].
- Round-robin arbitration starts at pointer ptr. The first eligible index at or after ptr, with wrap-around, is granted.
- req_ready is combinational from req_valid, outstanding and ptr.
- After a grant to i, ptr becomes (i+1) mod NUM_REQ. When there is no grant, ptr holds.
- Grant with opcode 00/01/10:
  - alu_in_valid, alu_op, alu_a and alu_b are registered and driven the next cycle.
  - When no issue occurs, alu_in_valid=0 and the data registers hold their values.
  - Tag pipeline of depth ALU_LAT+1 carries {valid, requester index}.
- Grant with opcode 11: no ALU issue. Response buffer i loads next cycle with rsp_data=0 and rsp_err=1.
- ALU result: when the tag at depth ALU_LAT+1 is valid, response buffer[tag] captures alu_out with rsp_err=0. rsp_valid is registered.
- protocol_err is set, and stays set until reset, when alu_out_valid differs from the tag-valid bit in any cycle. On a missing alu_out_valid, the buffer still loads alu_out.
- rsp_valid[i] and rsp_data[i] hold stable until rsp_ready[i].
- busy = |outstanding.
- The block does no arithmetic on payloads; they pass through bit-exact.

## Timing
- Reset, asynchronous: every output and register is 0, including ptr, outstanding, tags, alu_* and rsp_*. Reset asserted mid-operation discards all in-flight tags and buffered responses. ALU results arriving after reset release set protocol_err.
- Requester handshake at cycle T, valid opcode: alu_in_valid at T+1, alu_out_valid expected at T+1+ALU_LAT, rsp_valid at T+2+ALU_LAT.
- Reserved opcode: rsp_valid at T+1.
- Throughput: one issue per cycle across requesters. Per requester, the next grant can occur no earlier than one cycle after its response handshake.
- An ALU-result load and a reserved-op load in the same cycle always target different buffers, and both complete.
- Response handshake and new-request eligibility never overlap in the same cycle for the same requester.

## Test plan
- NEG, single requester: ALU_LAT=3, req 0 handshake at cycle 5 with scale 0x7F and elem[k]=k. Required: alu_in_valid=1 at cycle 6 only, rsp_valid[0] at cycle 10, rsp_data equal to the model ALU output, busy falling at cycle 11 after rsp_ready.
- All four requesters hold req_valid=1 from cycle 0: grants 0, 1, 2, 3 in cycles 0–3, then no grants until responses drain. Requester 0 is regranted the cycle after its response handshake.
- Requester 2, op=11, at cycle T: no alu_in_valid. rsp_valid[2]=1 at T+1 with rsp_err=1 and rsp_data=0.
- rsp_ready[1] held low for 20 cycles with req_valid[1]=1: rsp_data[1] remains stable, req_ready[1] stays 0, and other requesters keep being granted.
- alu_out_valid pulsed with no op in flight: protocol_err=1 next cycle and sticky, with no rsp_valid change.
- rst_n asserted two cycles after an issue, then released: all outputs 0, no rsp_valid ever appears for the dropped operation, and the next request completes with nominal latency.
